ifu_lsu_rd_arbiter: RTL and testbench
=====================================

Name: ifu_lsu_rd_arbiter

Overview:
- Two-master to one-slave AXI-Lite read-channel arbiter.
- Shares the single memory read port between the instruction fetch unit (IFU, master 0) and the load/store unit (LSU, master 1).
- Exactly one read transaction is outstanding at a time; the grant is held from AR acceptance until R completion.
- LSU writes are out of scope and bypass this block.

Parameters:
- AW, 32, address width
- DW, 32, data width

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
ifu_araddr  input  AW  IFU read address
ifu_arvalid  input  1  IFU address valid
ifu_arready  output  1  IFU address accepted
ifu_rvalid  output  1  IFU read data valid
ifu_rready  input  1  IFU ready for data
ifu_rdata  output  DW  IFU read data
ifu_rresp  output  2  IFU read response (forwarded)
lsu_araddr  input  AW  LSU read address
lsu_arvalid  input  1  LSU address valid
lsu_arready  output  1  LSU address accepted
lsu_rvalid  output  1  LSU read data valid
lsu_rready  input  1  LSU ready for data
lsu_rdata  output  DW  LSU read data
lsu_rresp  output  2  LSU read response (forwarded)
m_araddr  output  AW  slave address
m_arvalid  output  1  slave address valid
m_arready  input  1  slave address ready
m_rvalid  input  1  slave data valid
m_rready  output  1  slave data ready
m_rdata  input  DW  slave data
m_rresp  input  2  slave response
grant  output  2  one-hot current owner; bit0 IFU, bit1 LSU; 00 idle

Behaviour:
- Clock is clk. Reset is synchronous and active-high on reset. No other clock or reset.
- States: S_IDLE, S_AR, S_R. State and grant are registered.
- Reset: state=S_IDLE, grant=00. All valid/ready outputs are 0. m_araddr=0, and all rdata/rresp outputs are 0.
- S_IDLE:
  - If any arvalid is high, select the winner, set grant, go to S_AR next cycle.
  - Default priority is fixed: LSU wins over IFU.
  - Arbitration latency is 1 cycle: request sampled in cycle N, m_arvalid asserted in N+1.
  - No arready is asserted in S_IDLE.
- S_AR:
  - m_araddr and m_arvalid follow the granted master combinationally.
  - The granted arready equals m_arready; the other master's arready is 0.
  - On m_arvalid && m_arready, go to S_R.
  - If the granted master drops arvalid before the handshake (illegal per AXI), the arbiter still holds grant. The bench must not do this.
- S_R:
  - m_rready equals the granted master's rready.
  - The granted master's rvalid, rdata and rresp equal m_rvalid, m_rdata and m_rresp.
  - The ungranted master sees rvalid=0 and rdata/rresp=0.
  - On m_rvalid && m_rready, go to S_IDLE and clear grant. This gives one idle turnaround cycle, so there is no back-to-back grant.
- m_arvalid=0 outside S_AR; m_rready=0 outside S_R.
- Stray m_rvalid in S_IDLE or S_AR is ignored and not forwarded.
- Simultaneous requests: the loser stays pending; its arvalid is held by the master and re-arbitrated in the next S_IDLE.
- rresp is passed through unmodified, e.g. 2'b10 SLVERR becomes an IFU access fault.
- IFU redirect/epoch discard is the IFU's responsibility. The arbiter always completes the R handshake of a granted transaction.
- Reset mid-transaction returns to S_IDLE immediately. The in-flight slave response is dropped; the slave is reset by the same signal.

Optional Feature:
- Macro ARB_RR_EN.
- Defined:
  - Add a 1-bit registered last_owner, reset to IFU(0).
  - On contention in S_IDLE, the master other than last_owner wins.
  - last_owner updates when an R handshake completes.
  - Single requesters are unaffected.
- Undefined: fixed LSU priority; no last_owner register.

Test Plan:
- IFU only: ifu_araddr=0x30000000 in cycle 0, slave arready in cycle 2, rvalid with rdata=0x00000413 in cycle 4 -> grant=01 in cycles 1-4; ifu_rdata=0x00000413 and ifu_rvalid=1 in cycle 4; grant=00 in cycle 5.
- Contention: both arvalid in the same cycle (IFU 0x30000004, LSU 0x0F000010) -> LSU serviced first (m_araddr=0x0F000010), then IFU (0x30000004) after one idle cycle; lsu_arready never overlaps ifu_arready.
- Error pass-through: IFU read, slave m_rresp=2'b10 -> ifu_rresp=2'b10; lsu_rvalid stays 0.
- Backpressure: IFU holds rready=0 for 3 cycles after m_rvalid -> m_rready=0 and grant stays 01 until the rready cycle; an LSU request in the meantime waits.
- ARB_RR_EN: both masters request continuously for 4 transactions -> grant order LSU, IFU, LSU, IFU. Without the macro -> LSU x4 while LSU holds arvalid.
- Reset asserted in S_R -> next cycle grant=00, m_rready=0, all rvalid=0; a new IFU request is granted normally after reset deasserts.

Source files
------------

// File: rtl/ifu_lsu_rd_arbiter.sv
// -----------------------------------------------------------------------------
// ifu_lsu_rd_arbiter
//
// Two-master to one-slave AXI-Lite read-channel arbiter. The instruction fetch
// unit (IFU, master 0) and the load/store unit (LSU, master 1) share a single
// memory read port. Only one read is outstanding at a time: the grant is
// taken in S_IDLE, held through the AR handshake (S_AR) and the R handshake
// (S_R), then released with one idle turnaround cycle.
//
// Arbitration: fixed priority, LSU wins over IFU. When the macro ARB_RR_EN is
// defined, contention is resolved round-robin against a registered
// last_owner (reset to IFU); a single requester always wins.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   ifu_ar*/ifu_r*             IFU read address / read data channels
//   lsu_ar*/lsu_r*             LSU read address / read data channels
//   m_ar*/m_r*                 shared slave read address / read data channels
//   grant[1:0]                 one-hot owner: bit0 IFU, bit1 LSU, 00 idle
// -----------------------------------------------------------------------------
module ifu_lsu_rd_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  // IFU (master 0)
  input  logic [AW-1:0] ifu_araddr,
  input  logic          ifu_arvalid,
  output logic          ifu_arready,
  output logic          ifu_rvalid,
  input  logic          ifu_rready,
  output logic [DW-1:0] ifu_rdata,
  output logic [1:0]    ifu_rresp,
  // LSU (master 1)
  input  logic [AW-1:0] lsu_araddr,
  input  logic          lsu_arvalid,
  output logic          lsu_arready,
  output logic          lsu_rvalid,
  input  logic          lsu_rready,
  output logic [DW-1:0] lsu_rdata,
  output logic [1:0]    lsu_rresp,
  // Shared slave port
  output logic [AW-1:0] m_araddr,
  output logic          m_arvalid,
  input  logic          m_arready,
  input  logic          m_rvalid,
  output logic          m_rready,
  input  logic [DW-1:0] m_rdata,
  input  logic [1:0]    m_rresp,
  // Current owner
  output logic [1:0]    grant
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2
  } state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_IFU  = 2'b01;
  localparam logic [1:0] GNT_LSU  = 2'b10;

  state_t     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       sel_lsu;
  logic       own_arvalid;
  logic       own_rready;

`ifdef ARB_RR_EN
  // 0 = IFU, 1 = LSU; the master that most recently completed a read.
  logic last_owner_q, last_owner_d;
`endif

  // grant is one-hot, so bit1 alone selects the LSU path.
  assign sel_lsu     = grant_q[1];
  assign own_arvalid = sel_lsu ? lsu_arvalid : ifu_arvalid;
  assign own_rready  = sel_lsu ? lsu_rready  : ifu_rready;
  assign grant       = grant_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      grant_q <= GNT_NONE;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge clk) begin
    if (reset) last_owner_q <= 1'b0;
    else       last_owner_q <= last_owner_d;
  end
`endif

  // Next-state and output decode.
  always_comb begin
    // NOTE: every output gets a default before the case statement so no path
    // leaves a variable unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    grant_d     = grant_q;
`ifdef ARB_RR_EN
    last_owner_d = last_owner_q;
`endif
    m_araddr    = '0;
    m_arvalid   = 1'b0;
    m_rready    = 1'b0;
    ifu_arready = 1'b0;
    lsu_arready = 1'b0;
    ifu_rvalid  = 1'b0;
    lsu_rvalid  = 1'b0;
    ifu_rdata   = '0;
    lsu_rdata   = '0;
    ifu_rresp   = 2'b00;
    lsu_rresp   = 2'b00;

    unique case (state_q)
      S_IDLE: begin
        // Request seen here is presented to the slave in the next cycle.
        if (ifu_arvalid && lsu_arvalid) begin
`ifdef ARB_RR_EN
          grant_d = last_owner_q ? GNT_IFU : GNT_LSU;
`else
          grant_d = GNT_LSU;
`endif
          state_d = S_AR;
        end else if (lsu_arvalid) begin
          grant_d = GNT_LSU;
          state_d = S_AR;
        end else if (ifu_arvalid) begin
          grant_d = GNT_IFU;
          state_d = S_AR;
        end
      end

      S_AR: begin
        // Grant is held even if the owner illegally drops arvalid.
        m_araddr    = sel_lsu ? lsu_araddr : ifu_araddr;
        m_arvalid   = own_arvalid;
        ifu_arready = !sel_lsu && m_arready;
        lsu_arready =  sel_lsu && m_arready;
        if (own_arvalid && m_arready) state_d = S_R;
      end

      S_R: begin
        // Only the owner sees the response; m_rvalid in other states is a
        // stray beat and never reaches either master.
        m_rready = own_rready;
        if (sel_lsu) begin
          lsu_rvalid = m_rvalid;
          lsu_rdata  = m_rdata;
          lsu_rresp  = m_rresp;
        end else begin
          ifu_rvalid = m_rvalid;
          ifu_rdata  = m_rdata;
          ifu_rresp  = m_rresp;
        end
        if (m_rvalid && own_rready) begin
          state_d = S_IDLE;
          grant_d = GNT_NONE;
`ifdef ARB_RR_EN
          last_owner_d = sel_lsu;
`endif
        end
      end

      default: begin
        state_d = S_IDLE;
        grant_d = GNT_NONE;
      end
    endcase
  end

endmodule

// File: tb/tb_ifu_lsu_rd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ifu_lsu_rd_arbiter
//
// Directed scenarios (single IFU read, contention, error response with
// backpressure, continuous contention ordering, reset in the data phase)
// followed by a randomized run checked against a transaction-level model of
// the shared read port. Define ARB_RR_EN on both the bench and the design to
// exercise round-robin arbitration.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ifu_lsu_rd_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] ifu_araddr, lsu_araddr, m_araddr;
  logic          ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
  logic          lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
  logic [DW-1:0] ifu_rdata, lsu_rdata, m_rdata;
  logic [1:0]    ifu_rresp, lsu_rresp, m_rresp, grant;
  logic          m_arvalid, m_arready, m_rvalid, m_rready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ifu_lsu_rd_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
    .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready), .ifu_rdata(ifu_rdata),
    .ifu_rresp(ifu_rresp),
    .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
    .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready), .lsu_rdata(lsu_rdata),
    .lsu_rresp(lsu_rresp),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .grant(grant)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled on the
  // falling edge, so one "cycle" spans tick() .. next tick().
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    ifu_araddr = '0; ifu_arvalid = 0; ifu_rready = 0;
    lsu_araddr = '0; lsu_arvalid = 0; lsu_rready = 0;
    m_arready = 0; m_rvalid = 0; m_rdata = '0; m_rresp = 2'b00;
  endtask

  // Everything the masters and slave see must be quiet.
  task automatic check_quiet(input string tag);
    check({tag, "_grant"}, grant, 2'b00);
    check({tag, "_arready"}, {ifu_arready, lsu_arready}, 2'b00);
    check({tag, "_rvalid"}, {ifu_rvalid, lsu_rvalid}, 2'b00);
    check({tag, "_m_arvalid"}, m_arvalid, 1'b0);
    check({tag, "_m_rready"}, m_rready, 1'b0);
    check({tag, "_m_araddr"}, m_araddr, '0);
    check({tag, "_rdata"}, {ifu_rdata, lsu_rdata, ifu_rresp, lsu_rresp}, '0);
  endtask

  task automatic do_reset();
    reset = 1;
    idle_inputs();
    tick();
    tick();
    // Stray slave response while in reset must not leak through.
    m_rvalid = 1; m_rdata = 32'hDEAD_BEEF; m_rresp = 2'b11;
    settle();
    check_quiet("rst");
    tick();
    reset = 0;
    m_rvalid = 0; m_rdata = '0; m_rresp = 2'b00;
  endtask

  function automatic logic [DW-1:0] slave_data(input logic [AW-1:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5C3_0F96;
  endfunction

  function automatic logic [1:0] slave_resp(input logic [AW-1:0] a);
    return a[3:2];
  endfunction

  // Contention winner from the arbitration rule; 0 = IFU, 1 = LSU.
  function automatic int pick(input bit ifu_req, input bit lsu_req, input bit last);
    if (ifu_req && lsu_req) begin
`ifdef ARB_RR_EN
      return last ? 0 : 1;
`else
      return 1;
`endif
    end
    return lsu_req ? 1 : 0;
  endfunction

  // ---------------------------------------------------------------------------
  task automatic test_ifu_only();
    do_reset();
    ifu_araddr = 32'h3000_0000; ifu_arvalid = 1; ifu_rready = 1;        // c0
    settle();
    check("t1_c0_grant", grant, 2'b00);
    check("t1_c0_m_arvalid", m_arvalid, 1'b0);
    check("t1_c0_ifu_arready", ifu_arready, 1'b0);
    tick();                                                              // c1
    settle();
    check("t1_c1_grant", grant, 2'b01);
    check("t1_c1_m_arvalid", m_arvalid, 1'b1);
    check("t1_c1_m_araddr", m_araddr, 32'h3000_0000);
    check("t1_c1_ifu_arready", ifu_arready, 1'b0);
    tick(); m_arready = 1;                                               // c2
    settle();
    check("t1_c2_grant", grant, 2'b01);
    check("t1_c2_arready", {ifu_arready, lsu_arready}, 2'b10);
    tick(); ifu_arvalid = 0; m_arready = 0;                              // c3
    settle();
    check("t1_c3_grant", grant, 2'b01);
    check("t1_c3_m_arvalid", m_arvalid, 1'b0);
    check("t1_c3_ifu_rvalid", ifu_rvalid, 1'b0);
    tick(); m_rvalid = 1; m_rdata = 32'h0000_0413;                       // c4
    settle();
    check("t1_c4_grant", grant, 2'b01);
    check("t1_c4_ifu_rvalid", ifu_rvalid, 1'b1);
    check("t1_c4_ifu_rdata", ifu_rdata, 32'h0000_0413);
    check("t1_c4_m_rready", m_rready, 1'b1);
    check("t1_c4_lsu_rvalid", lsu_rvalid, 1'b0);
    tick(); m_rvalid = 0; m_rdata = '0;                                  // c5
    settle();
    check("t1_c5_grant", grant, 2'b00);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_contention();
    logic [AW-1:0] order [$];
    do_reset();
    ifu_araddr = 32'h3000_0004; ifu_arvalid = 1; ifu_rready = 1;
    lsu_araddr = 32'h0F00_0010; lsu_arvalid = 1; lsu_rready = 1;
    m_arready = 1; m_rvalid = 1; m_rdata = 32'h1234_5678;
    for (int c = 0; c < 10; c++) begin
      settle();
      check("t2_no_overlap", ifu_arready & lsu_arready, 1'b0);
      if (c == 3) check("t2_turnaround_grant", grant, 2'b00);
      if (m_arvalid && m_arready) order.push_back(m_araddr);
      tick();
      if (ifu_arvalid && dut.ifu_arready === 1'b0 && 0) ifu_arvalid = 0;
      // Drop arvalid once each master's address has been taken.
      if (order.size() >= 1) lsu_arvalid = 0;
      if (order.size() >= 2) ifu_arvalid = 0;
    end
    check("t2_count", order.size(), 2);
    if (order.size() >= 2) begin
      check("t2_first_lsu", order[0], 32'h0F00_0010);
      check("t2_second_ifu", order[1], 32'h3000_0004);
    end
    idle_inputs();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_err_backpressure();
    do_reset();
    ifu_araddr = 32'h3000_0008; ifu_arvalid = 1; ifu_rready = 0;        // c0
    tick(); m_arready = 1;                                               // c1
    settle();
    check("t3_c1_ifu_arready", ifu_arready, 1'b1);
    tick(); ifu_arvalid = 0; m_arready = 0;                              // c2
    m_rvalid = 1; m_rdata = 32'hDEAD_0001; m_rresp = 2'b10;
    lsu_araddr = 32'h0F00_0020; lsu_arvalid = 1; lsu_rready = 1;
    for (int c = 2; c < 5; c++) begin
      settle();
      check("t3_bp_m_rready", m_rready, 1'b0);
      check("t3_bp_grant", grant, 2'b01);
      check("t3_bp_ifu_rvalid", ifu_rvalid, 1'b1);
      check("t3_bp_ifu_rresp", ifu_rresp, 2'b10);
      check("t3_bp_lsu_side", {lsu_rvalid, lsu_arready}, 2'b00);
      tick();
    end
    ifu_rready = 1;                                                      // c5
    settle();
    check("t3_c5_m_rready", m_rready, 1'b1);
    check("t3_c5_ifu_rresp", ifu_rresp, 2'b10);
    check("t3_c5_lsu_rvalid", lsu_rvalid, 1'b0);
    tick(); m_rvalid = 0; m_rresp = 2'b00; m_rdata = '0;                 // c6
    settle();
    check("t3_c6_grant", grant, 2'b00);
    tick();                                                              // c7
    settle();
    check("t3_c7_grant", grant, 2'b10);
    check("t3_c7_m_araddr", m_araddr, 32'h0F00_0020);
    tick(); m_arready = 1;                                               // c8
    tick(); lsu_arvalid = 0; m_arready = 0; m_rvalid = 1;                // c9
    tick(); m_rvalid = 0;                                                // c10
    settle();
    check("t3_c10_grant", grant, 2'b00);
    idle_inputs();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_continuous();
    logic [AW-1:0] order [$];
    logic [AW-1:0] exp_order [4];
    do_reset();
    ifu_araddr = 32'h3000_0000; ifu_arvalid = 1; ifu_rready = 1;
    lsu_araddr = 32'h0F00_0000; lsu_arvalid = 1; lsu_rready = 1;
    m_arready = 1; m_rvalid = 1; m_rdata = 32'h0000_0013;
    for (int c = 0; c < 20; c++) begin
      settle();
      check("t4_no_overlap", ifu_arready & lsu_arready, 1'b0);
      if (m_arvalid && m_arready) order.push_back(m_araddr);
      tick();
    end
`ifdef ARB_RR_EN
    exp_order = '{32'h0F00_0000, 32'h3000_0000, 32'h0F00_0000, 32'h3000_0000};
`else
    exp_order = '{32'h0F00_0000, 32'h0F00_0000, 32'h0F00_0000, 32'h0F00_0000};
`endif
    check("t4_enough_txns", order.size() >= 4, 1'b1);
    for (int i = 0; i < 4; i++)
      if (i < order.size()) check($sformatf("t4_order%0d", i), order[i], exp_order[i]);
    idle_inputs();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_in_r();
    do_reset();
    ifu_araddr = 32'h3000_0010; ifu_arvalid = 1; ifu_rready = 1;        // c0
    tick(); m_arready = 1;                                               // c1
    tick(); ifu_arvalid = 0; m_arready = 0;                              // c2 (S_R)
    settle();
    check("t5_c2_grant", grant, 2'b01);
    reset = 1;
    tick(); reset = 0;                                                   // c3
    m_rvalid = 1; m_rdata = 32'h0BAD_0BAD;
    ifu_araddr = 32'h3000_0040; ifu_arvalid = 1;
    settle();
    check_quiet("t5_c3");
    tick(); m_rvalid = 0; m_rdata = '0;                                  // c4
    settle();
    check("t5_c4_grant", grant, 2'b01);
    check("t5_c4_m_araddr", m_araddr, 32'h3000_0040);
    tick(); m_arready = 1;                                               // c5
    tick(); ifu_arvalid = 0; m_arready = 0; m_rvalid = 1;                // c6
    m_rdata = 32'h0000_0777;
    settle();
    check("t5_c6_ifu_rdata", ifu_rdata, 32'h0000_0777);
    tick(); m_rvalid = 0;                                                // c7
    settle();
    check("t5_c7_grant", grant, 2'b00);
    idle_inputs();
  endtask

  // ---------------------------------------------------------------------------
  // Randomized run. The model treats the port as one shared resource: owner
  // (-1 free, 0 IFU, 1 LSU), whether its address has been taken, and which
  // address it is serving. The slave answers with data derived from the
  // captured address after a random delay and emits stray beats when idle.
  task automatic test_random(input int cycles);
    int            owner = -1;
    bit            in_r = 0, last = 0;
    bit            ifu_out = 0, lsu_out = 0;
    logic [AW-1:0] cur_addr = '0;
    bit            s_busy = 0;
    int            s_delay = 0;
    logic [AW-1:0] s_addr = '0;
    int            n_done = 0;
    do_reset();
    for (int c = 0; c < cycles; c++) begin
      bit            own_arv, own_rdy, own_arr, oth_arr, own_rv, oth_rv;
      bit            hs_ar, hs_r, s_hs, s_rdone, req;
      int            winner;
      logic [AW-1:0] own_addr, cap_addr;
      logic [DW-1:0] own_rd, oth_rd;
      logic [1:0]    own_rr;
      settle();
      own_arv  = (owner == 1) ? lsu_arvalid : ifu_arvalid;
      own_addr = (owner == 1) ? lsu_araddr  : ifu_araddr;
      own_rdy  = (owner == 1) ? lsu_rready  : ifu_rready;
      own_arr  = (owner == 1) ? lsu_arready : ifu_arready;
      oth_arr  = (owner == 1) ? ifu_arready : lsu_arready;
      own_rv   = (owner == 1) ? lsu_rvalid  : ifu_rvalid;
      oth_rv   = (owner == 1) ? ifu_rvalid  : lsu_rvalid;
      own_rd   = (owner == 1) ? lsu_rdata   : ifu_rdata;
      oth_rd   = (owner == 1) ? ifu_rdata   : lsu_rdata;
      own_rr   = (owner == 1) ? lsu_rresp   : ifu_rresp;
      check("rnd_grant", grant, (owner < 0) ? 2'b00 : (owner == 1 ? 2'b10 : 2'b01));
      check("rnd_ar_overlap", ifu_arready & lsu_arready, 1'b0);
      if (owner < 0) begin
        check("rnd_idle_quiet", {ifu_arready, lsu_arready, ifu_rvalid, lsu_rvalid,
                                 m_arvalid, m_rready}, 6'b0);
      end else if (!in_r) begin
        check("rnd_ar_m_arvalid", m_arvalid, own_arv);
        check("rnd_ar_m_araddr", m_araddr, own_addr);
        check("rnd_ar_own_arready", own_arr, m_arready);
        check("rnd_ar_other", {oth_arr, m_rready, ifu_rvalid, lsu_rvalid}, 4'b0);
      end else begin
        check("rnd_r_m_rready", m_rready, own_rdy);
        check("rnd_r_own_rvalid", own_rv, m_rvalid);
        if (m_rvalid) begin
          check("rnd_r_rdata", own_rd, slave_data(cur_addr));
          check("rnd_r_rresp", own_rr, slave_resp(cur_addr));
        end
        check("rnd_r_other", {oth_rv, oth_rd, m_arvalid}, '0);
      end
      hs_ar    = (owner >= 0) && !in_r && own_arv && m_arready;
      hs_r     = (owner >= 0) && in_r && m_rvalid && own_rdy;
      req      = ifu_arvalid || lsu_arvalid;
      winner   = pick(ifu_arvalid, lsu_arvalid, last);
      s_hs     = m_arvalid && m_arready;
      s_rdone  = s_busy && m_rvalid && m_rready;
      cap_addr = m_araddr;
      tick();
      // Model / master update.
      if (owner < 0) begin
        if (req) begin
          owner    = winner;
          in_r     = 0;
          cur_addr = (winner == 1) ? lsu_araddr : ifu_araddr;
        end
      end else if (hs_ar) begin
        in_r = 1;
        if (owner == 1) begin lsu_arvalid = 0; lsu_out = 1; end
        else            begin ifu_arvalid = 0; ifu_out = 1; end
      end else if (hs_r) begin
        last = (owner == 1);
        if (owner == 1) lsu_out = 0; else ifu_out = 0;
        owner = -1;
        n_done++;
      end
      // Slave.
      if (s_hs) begin
        s_busy = 1; s_addr = cap_addr; s_delay = $urandom_range(3);
        m_rvalid = 0;
      end else if (s_rdone) begin
        s_busy = 0; m_rvalid = 0;
      end
      if (s_busy) begin
        if (!m_rvalid) begin
          if (s_delay == 0) begin
            m_rvalid = 1; m_rdata = slave_data(s_addr); m_rresp = slave_resp(s_addr);
          end else s_delay--;
        end
      end else begin
        m_rvalid = ($urandom_range(3) == 0);
        m_rdata  = $urandom;
        m_rresp  = 2'($urandom_range(3));
      end
      m_arready = $urandom_range(1);
      // Masters: one read of their own at a time, arvalid held until taken.
      if (!ifu_arvalid && !ifu_out && $urandom_range(2) == 0) begin
        ifu_arvalid = 1; ifu_araddr = {4'h3, 28'($urandom)};
      end
      if (!lsu_arvalid && !lsu_out && $urandom_range(2) == 0) begin
        lsu_arvalid = 1; lsu_araddr = {4'h0, 28'($urandom)};
      end
      ifu_rready = ($urandom_range(3) != 0);
      lsu_rready = ($urandom_range(3) != 0);
    end
    check("rnd_progress", n_done > 100, 1'b1);
    idle_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1;
    idle_inputs();
    test_ifu_only();
    test_contention();
    test_err_backpressure();
    test_continuous();
    test_reset_in_r();
    test_random(3000);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
